// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the MMIO UART transmitter: the 0xf region register map
// and the serializer state encoding.
package mmio_uart_tx_pkg;

    localparam logic [31:0] MmioHalt      = 32'hf000_0000;
    localparam logic [31:0] MmioUartData  = 32'hf000_0100;
    localparam logic [31:0] MmioUartTxcnt = 32'hf000_0104;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Processor data-port bundle (mem_*) seen by memory-mapped peripherals.
interface mmio_uart_tx_if;

    logic        mem_oe;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;
    logic        mem_valid;

    modport master (
        output mem_oe, mem_addr, mem_wdata, mem_we,
        input  mem_rdata, mem_valid
    );

    modport slave (
        input  mem_oe, mem_addr, mem_wdata, mem_we,
        output mem_rdata, mem_valid
    );

endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock circular-buffer FIFO. A push is judged against the count at the
// edge, so a push into a full FIFO is dropped even when a pop happens that cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LOG2  = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LOG2:0]    count_o
);

    localparam int unsigned Depth = 1 << LOG2;

    logic [WIDTH-1:0] mem_q [Depth];
    logic [LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LOG2:0]    count_q, count_d;
    logic             push_en, pop_en;

    assign full_o  = (count_q == (LOG2+1)'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        push_en  = push_i && !full_o;
        pop_en   = pop_i && !empty_o;
        wr_ptr_d = push_en ? wr_ptr_q + LOG2'(1) : wr_ptr_q;
        rd_ptr_d = pop_en ? rd_ptr_q + LOG2'(1) : rd_ptr_q;
        count_d  = count_q + (LOG2+1)'(push_en) - (LOG2+1)'(pop_en);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO and TX-available status.
// Define MMIO_UART_TXCNT_EN to add a completed-frame counter at BASE+4.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE      = MmioUartData,
    parameter int unsigned CLK_DIV   = 16,
    parameter int unsigned FIFO_LOG2 = 4
) (
    input  logic         clk,
    input  logic         rst,
    mmio_uart_tx_if.slave bus,
    output logic         tx,
    output logic         busy
);

    localparam int unsigned BaudW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLK_DIV - 1);

    uart_state_e      state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             valid_q, valid_d;
    logic [31:0]      rdata_q, rdata_d;

    logic             sel_data, wr_data, rd_data;
    logic             fifo_pop, fifo_full, fifo_empty;
    logic [7:0]       fifo_rdata;
    logic [FIFO_LOG2:0] fifo_count;
    logic             baud_end;
    logic             unused_bus;

    assign sel_data = bus.mem_oe && (bus.mem_addr == BASE);
    assign wr_data  = sel_data && bus.mem_we[0];
    // Any access without byte lane 0 enabled behaves as a read.
    assign rd_data  = sel_data && !bus.mem_we[0];
    assign unused_bus = ^{bus.mem_wdata[31:8], bus.mem_we[3:1]};

    sync_fifo #(
        .WIDTH (8),
        .LOG2  (FIFO_LOG2)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (wr_data),
        .wdata_i (bus.mem_wdata[7:0]),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign baud_end = (baud_q == BaudLast);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    baud_d   = '0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (baud_end) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = StData;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StStop: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = StIdle;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // tx is registered from the next state so the line never glitches.
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

`ifdef MMIO_UART_TXCNT_EN
    logic [31:0] txcnt_q, txcnt_d;
    logic        sel_cnt, rd_cnt, clr_cnt, frame_done;

    assign sel_cnt    = bus.mem_oe && (bus.mem_addr == BASE + 32'd4);
    assign rd_cnt     = sel_cnt && !bus.mem_we[0];
    assign clr_cnt    = sel_cnt && bus.mem_we[0];
    assign frame_done = (state_q == StStop) && baud_end;

    // Clear wins over a same-cycle increment.
    always_comb begin
        txcnt_d = txcnt_q;
        if (clr_cnt) begin
            txcnt_d = '0;
        end else if (frame_done) begin
            txcnt_d = txcnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txcnt_q <= '0;
        end else begin
            txcnt_q <= txcnt_d;
        end
    end
`endif

    always_comb begin
        valid_d = 1'b0;
        rdata_d = rdata_q;
        if (rd_data) begin
            valid_d = 1'b1;
            rdata_d = {31'b0, !fifo_full};
        end
`ifdef MMIO_UART_TXCNT_EN
        else if (rd_cnt) begin
            valid_d = 1'b1;
            rdata_d = txcnt_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            valid_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            valid_q   <= valid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign tx            = tx_q;
    assign busy          = (state_q != StIdle) || (fifo_count != '0);
    assign bus.mem_valid = valid_q;
    assign bus.mem_rdata = rdata_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: vector table, hand-written corner sequences and random
// bus traffic against a frame-level model plus an independent serial decoder.
module tb_mmio_uart_tx;
    import mmio_uart_tx_pkg::*;

    localparam int unsigned ClkDiv   = 4;
    localparam int unsigned FifoLog2 = 4;
    localparam int unsigned Depth    = 16;
    localparam logic [31:0] Base     = MmioUartData;
    localparam int unsigned BitNs    = ClkDiv * 10;
    localparam int unsigned FrameCyc = 10 * ClkDiv;
`ifdef MMIO_UART_TXCNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx, busy;

    always #5 clk = ~clk;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .BASE      (Base),
        .CLK_DIV   (ClkDiv),
        .FIFO_LOG2 (FifoLog2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .tx   (tx),
        .busy (busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Frame-level model: occupancy count and the earliest edge the serializer may pop.
    int          k         = 0;
    int          m_count   = 0;
    int          next_ok   = 0;
    int          frame_end = 0;
    logic [31:0] m_frames  = '0;
    logic        m_valid   = 1'b0;
    logic [31:0] m_rdata   = '0;
    logic        m_busy    = 1'b0;
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];
    int          frame_err = 0;

    typedef struct {
        logic        oe;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic        exp_valid;
        logic [31:0] exp_rdata;
        logic        exp_busy;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_count   = 0;
        next_ok   = 0;
        frame_end = 0;
        m_frames  = '0;
        m_valid   = 1'b0;
        m_rdata   = '0;
        m_busy    = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_edge(input logic oe, input logic [31:0] addr, input logic [3:0] we,
                              input logic [31:0] wdata);
        bit full, is_base, is_cnt, pop, push;
        full    = (m_count == Depth);
        is_base = oe && (addr == Base);
        is_cnt  = CntEn && oe && (addr == Base + 32'd4);
        m_valid = (is_base || is_cnt) && !we[0];
        if (is_base && !we[0]) m_rdata = {31'b0, !full};
        else if (is_cnt && !we[0]) m_rdata = m_frames;
        if (frame_end != 0 && k == frame_end) m_frames = m_frames + 32'd1;
        if (is_cnt && we[0]) m_frames = '0;
        pop  = (m_count > 0) && (k >= next_ok);
        push = is_base && we[0] && !full;
        if (pop) begin
            frame_end = k + FrameCyc;
            next_ok   = k + FrameCyc + 1;
        end
        if (push) exp_q.push_back(wdata[7:0]);
        m_count = m_count + int'(push) - int'(pop);
        m_busy  = (m_count > 0) || (k < frame_end);
    endtask

    task automatic bus_cycle(input logic oe, input logic [31:0] addr, input logic [3:0] we,
                             input logic [31:0] wdata);
        bus.mem_oe    = oe;
        bus.mem_addr  = addr;
        bus.mem_we    = we;
        bus.mem_wdata = wdata;
        @(posedge clk);
        k++;
        model_edge(oe, addr, we, wdata);
        @(negedge clk);
        check("mem_valid", {31'b0, bus.mem_valid}, {31'b0, m_valid});
        check("mem_rdata", bus.mem_rdata, m_rdata);
        check("busy", {31'b0, busy}, {31'b0, m_busy});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_cycle(1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && m_busy; i++) idle(1);
        check("drain_busy", {31'b0, busy}, 32'h0);
        idle(2);
    endtask

    task automatic compare_rx();
        check("rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check("rx_byte", {24'h0, rx_q[i]}, {24'h0, exp_q[i]});
        end
        exp_q.delete();
        rx_q.delete();
    endtask

    // Independent 8N1 receiver: samples each bit near its middle.
    initial begin : rx_decoder
        logic [7:0] b;
        forever begin
            @(negedge tx);
            #(BitNs / 2 + 2);
            if (tx === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    #(BitNs);
                    b[i] = tx;
                end
                #(BitNs);
                if (tx !== 1'b1) frame_err++;
                rx_q.push_back(b);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [9:0] frame;
        logic [7:0] rbyte;

        tbl[0] = '{1'b1, Base,          4'h0, 32'h0,  1'b1, 32'h1, 1'b0};
        tbl[1] = '{1'b1, MmioHalt,      4'h0, 32'h0,  1'b0, 32'h1, 1'b0};
        tbl[2] = '{1'b1, MmioHalt,      4'hf, 32'h55, 1'b0, 32'h1, 1'b0};
        tbl[3] = '{1'b1, 32'h0000_1000, 4'h0, 32'h0,  1'b0, 32'h1, 1'b0};
        tbl[4] = '{1'b1, 32'h0000_1000, 4'h1, 32'h66, 1'b0, 32'h1, 1'b0};
        tbl[5] = '{1'b1, Base,          4'h2, 32'h77, 1'b1, 32'h1, 1'b0};
        tbl[6] = '{1'b1, Base + 32'd8,  4'h0, 32'h0,  1'b0, 32'h1, 1'b0};
        tbl[7] = '{1'b0, Base,          4'h0, 32'h0,  1'b0, 32'h1, 1'b0};
        tbl[8] = '{1'b1, Base + 32'd8,  4'h1, 32'h88, 1'b0, 32'h1, 1'b0};
`ifdef MMIO_UART_TXCNT_EN
        tbl[9] = '{1'b1, Base + 32'd4,  4'h0, 32'h0,  1'b1, 32'h0, 1'b0};
`else
        tbl[9] = '{1'b1, Base + 32'd4,  4'h0, 32'h0,  1'b0, 32'h1, 1'b0};
`endif

        bus.mem_oe    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_we    = '0;
        bus.mem_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'b0, tx}, 32'h1);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_valid", {31'b0, bus.mem_valid}, 32'h0);
        check("rst_rdata", bus.mem_rdata, 32'h0);
        rst = 1'b1;

        // Address decode table, from the idle, empty state.
        for (int i = 0; i < 10; i++) begin
            bus_cycle(tbl[i].oe, tbl[i].addr, tbl[i].we, tbl[i].wdata);
            check("tbl_valid", {31'b0, bus.mem_valid}, {31'b0, tbl[i].exp_valid});
            check("tbl_rdata", bus.mem_rdata, tbl[i].exp_rdata);
            check("tbl_busy", {31'b0, busy}, {31'b0, tbl[i].exp_busy});
            check("tbl_tx", {31'b0, tx}, 32'h1);
        end
        idle(2 * FrameCyc);
        compare_rx();

        // Single frame: exact serial waveform.
        bus_cycle(1'b1, Base, 4'h1, 32'h41);
        frame = {1'b1, 8'h41, 1'b0};
        for (int i = 0; i < int'(FrameCyc); i++) begin
            idle(1);
            check("tx_41", {31'b0, tx}, {31'b0, frame[i / ClkDiv]});
        end
        check("busy_stop", {31'b0, busy}, 32'h1);
        idle(1);
        check("busy_fall", {31'b0, busy}, 32'h0);
        idle(2);
        compare_rx();

        // Burst of 17: the first is popped early, so all fit; the 18th is dropped.
        for (int i = 0; i < 17; i++) bus_cycle(1'b1, Base, 4'h1, i);
        bus_cycle(1'b1, Base, 4'h1, 32'hee);
        bus_cycle(1'b1, Base, 4'h0, 32'h0);
        check("full_status", bus.mem_rdata, 32'h0);
        drain();
        check("burst_count", 32'(rx_q.size()), 32'd17);
        for (int i = 0; i < 17 && i < rx_q.size(); i++) begin
            check("burst_byte", {24'h0, rx_q[i]}, i);
        end
        exp_q.delete();
        rx_q.delete();

        // Random bus traffic against the model.
        for (int n = 0; n < 700; n++) begin
            int unsigned r;
            logic [3:0]  w;
            r = $urandom_range(0, 99);
            w = 4'($urandom_range(0, 15));
            if (r < 40)      bus_cycle(1'b0, $urandom, w, $urandom);
            else if (r < 75) bus_cycle(1'b1, Base, w | 4'h1, $urandom);
            else if (r < 88) bus_cycle(1'b1, Base, w & 4'he, $urandom);
            else if (r < 93) bus_cycle(1'b1, Base + 32'd4, w, $urandom);
            else             bus_cycle(1'b1, r[0] ? MmioHalt : 32'h0000_1000, w, $urandom);
        end
        drain();
        compare_rx();

        // Asynchronous reset in the middle of data bit 3.
        rbyte = 8'ha5;
        bus_cycle(1'b1, Base, 4'h1, {24'h0, rbyte});
        idle(18);
        check("tx_bit3", {31'b0, tx}, {31'b0, rbyte[3]});
        #2 rst = 1'b0;
        #1;
        check("arst_tx", {31'b0, tx}, 32'h1);
        check("arst_busy", {31'b0, busy}, 32'h0);
        @(posedge clk);
        k++;
        model_reset();
        @(negedge clk);
        check("arst_tx_hold", {31'b0, tx}, 32'h1);
        check("arst_valid", {31'b0, bus.mem_valid}, 32'h0);
        rst = 1'b1;
        idle(80);
        rx_q.delete();
        bus_cycle(1'b1, Base, 4'h1, 32'h5a);
        drain();
        compare_rx();

`ifdef MMIO_UART_TXCNT_EN
        bus_cycle(1'b1, Base + 32'd4, 4'h1, 32'h0);
        for (int i = 0; i < 3; i++) bus_cycle(1'b1, Base, 4'h1, 32'h30 + i);
        drain();
        bus_cycle(1'b1, Base + 32'd4, 4'h0, 32'h0);
        check("txcnt_3", bus.mem_rdata, 32'd3);
        bus_cycle(1'b1, Base + 32'd4, 4'h1, 32'h0);
        bus_cycle(1'b1, Base + 32'd4, 4'h0, 32'h0);
        check("txcnt_clr", bus.mem_rdata, 32'd0);
        compare_rx();
`endif

        check("frame_err", frame_err, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
